stdcore_spram_lane: RTL and testbench

Parametrised single-port SRAM model with per-lane write masking, an optional output pipeline register, and a hardware clear sequencer. It is the successor to the plain single-port macro wrapper and is used wherever line buffers or reference caches need partial-word writes and a known-zero start state. The clear sequencer runs after reset and on request. Storage stays a behavioural array, so the block can later be mapped onto library macros.

---
 rtl/stdcore_pkg.sv | 38 +++
 rtl/stdcore_clr_seq.sv | 57 +++++
 rtl/stdcore_spram_lane.sv | 155 +++++++++++++++
 tb/tb_stdcore_spram_lane.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stdcore_pkg.sv
// Shared types and helpers for the stdcore single-port RAM lane family.
package stdcore_pkg;

    // Upper bounds for the generic lane merge; callers zero/one-extend into these.
    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_NL = 256;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CLR  = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Replace every lane whose active-low enable is 0 with the new data.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NL-1:0] mask_n,
        input int unsigned       lw
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int unsigned b = 0; b < MAX_DW; b++) begin
            if (!mask_n[b / lw]) res[b] = new_w[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/stdcore_clr_seq.sv
// Clear sequencer: owns the idle/clear FSM and the sweep address counter.
module stdcore_clr_seq
    import stdcore_pkg::*;
#(
    parameter int unsigned AW       = 4,
    parameter int unsigned DEPTH    = 16,
    parameter bit          INIT_CLR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // State and sweep counter registers; reset restarts the sweep from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT_CLR ? S_CLR : S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: a request in idle starts a sweep; requests mid-sweep are ignored.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) state_d = S_CLR;
            end
            S_CLR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_CLR);
    assign clr_we   = (state_q == S_CLR);
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/stdcore_spram_lane.sv
// Single-port SRAM with per-lane write masks, optional output register and
// a hardware clear sweep that fills the array with CLR_VAL.
module stdcore_spram_lane
    import stdcore_pkg::*;
#(
    parameter int unsigned   DW       = 32,
    parameter int unsigned   LW       = 8,
    parameter int unsigned   AW       = 4,
    parameter int unsigned   DEPTH    = 16,
    parameter bit            OREG     = 1'b0,
    parameter bit            INIT_CLR = 1'b1,
    parameter logic [DW-1:0] CLR_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_n,
    input  logic             we_n,
    input  logic [DW/LW-1:0] wmask_n,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    input  logic             clr_req,
    output logic             busy,
    output logic             oor_err
);

    localparam int unsigned NL = DW / LW;
    localparam int unsigned IW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          in_range;
    logic          user_acc;

    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          rd_fire;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          rv1_q, rv1_d;
    logic          oor_q, oor_d;

    stdcore_clr_seq #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .INIT_CLR (INIT_CLR)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
    assign user_acc = !busy && !ce_n;
    assign rd_fire  = user_acc && we_n;

    // ---------------- storage array and read/output stage ----------------

    logic [DW-1:0] mem_q [DEPTH];

    // Array port mux: the sweep owns the port while busy, else the user port.
    // Upper mask bits are forced to 1 so padding lanes are never enabled.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr[IW-1:0];
            mem_wdata = CLR_VAL;
        end else if (user_acc && !we_n && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = addr[IW-1:0];
            mem_wdata = DW'(lane_merge(MAX_DW'(mem_q[addr[IW-1:0]]),
                                       MAX_DW'(wdata),
                                       ~MAX_NL'(~wmask_n),
                                       LW));
        end
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // First read stage: capture on a read, hold otherwise; out-of-range reads give 0.
    always_comb begin
        rd_word = in_range ? mem_q[addr[IW-1:0]] : '0;
        rd1_d   = rd_fire ? rd_word : rd1_q;
        rv1_d   = rd_fire;
    end

    // First read stage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_q <= '0;
            rv1_q <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            rv1_q <= rv1_d;
        end
    end

    generate
        if (OREG) begin : g_oreg
            logic [DW-1:0] rd2_q, rd2_d;
            logic          rv2_q, rv2_d;

            // Output stage forwards the first stage one cycle later and holds otherwise.
            always_comb begin
                rd2_d = rv1_q ? rd1_q : rd2_q;
                rv2_d = rv1_q;
            end

            // Output stage registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd2_q <= '0;
                    rv2_q <= 1'b0;
                end else begin
                    rd2_q <= rd2_d;
                    rv2_q <= rv2_d;
                end
            end

            assign rdata  = rd2_q;
            assign rvalid = rv2_q;
        end else begin : g_noreg
            assign rdata  = rd1_q;
            assign rvalid = rv1_q;
        end
    endgenerate

    // ---------------- end of storage section ----------------

    // Sticky out-of-range flag, set by any accepted access outside the array.
    always_comb begin
        oor_d = oor_q | (user_acc && !in_range);
    end

    // Out-of-range flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) oor_q <= 1'b0;
        else        oor_q <= oor_d;
    end

    assign oor_err = oor_q;

endmodule

// File: tb/tb_stdcore_spram_lane.sv
// Scoreboard bench: one DUT without and one with the output register share
// the same stimulus; monitors pop expected read data and issue cycle.
module tb_stdcore_spram_lane;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ce_n;
    logic        we_n;
    logic [3:0]  wmask_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        clr_req;

    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        busy0, busy1;
    logic        oor0, oor1;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned cyc;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [12];

    stdcore_spram_lane #(
        .DW(32), .LW(8), .AW(4), .DEPTH(12), .OREG(1'b0), .INIT_CLR(1'b1), .CLR_VAL(CV)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .wmask_n(wmask_n),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0),
        .clr_req(clr_req), .busy(busy0), .oor_err(oor0)
    );

    stdcore_spram_lane #(
        .DW(32), .LW(8), .AW(4), .DEPTH(12), .OREG(1'b1), .INIT_CLR(1'b1), .CLR_VAL(CV)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .wmask_n(wmask_n),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1),
        .clr_req(clr_req), .busy(busy1), .oor_err(oor1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor for the unregistered instance: latency 1.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid0) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL rd0_unexpected got=%h exp=none", rdata0);
            end else begin
                e = q0.pop_front();
                if (rdata0 !== e.data || cyc != e.cyc + 1) begin
                    miscompares++;
                    $display("FAIL rd0 got=%h@%0d exp=%h@%0d", rdata0, cyc, e.data, e.cyc + 1);
                end
            end
        end
    end

    // Monitor for the registered instance: latency 2.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL rd1_unexpected got=%h exp=none", rdata1);
            end else begin
                e = q1.pop_front();
                if (rdata1 !== e.data || cyc != e.cyc + 2) begin
                    miscompares++;
                    $display("FAIL rd1 got=%h@%0d exp=%h@%0d", rdata1, cyc, e.data, e.cyc + 2);
                end
            end
        end
    end

    task automatic rd(input int unsigned a, input logic [31:0] e);
        exp_t x;
        ce_n = 1'b0; we_n = 1'b1; addr = 4'(a);
        x.data = e; x.cyc = cyc;
        q0.push_back(x);
        q1.push_back(x);
        @(negedge clk);
        ce_n = 1'b1;
    endtask

    task automatic wr(input int unsigned a, input logic [31:0] d, input logic [3:0] m);
        ce_n = 1'b0; we_n = 1'b0; addr = 4'(a); wdata = d; wmask_n = m;
        if (a < 12) begin
            for (int i = 0; i < 4; i++) begin
                if (!m[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        @(negedge clk);
        ce_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_fill();
        for (int i = 0; i < 12; i++) model[i] = CV;
    endtask

    // Count cycles with busy high; a write and a read are attempted mid-sweep
    // and must both be dropped (no scoreboard entry pushed).
    task automatic count_busy(input string nm, input bit poke);
        int unsigned n;
        n = 0;
        while (busy0 && n < 200) begin
            if (poke && n == 3) begin
                ce_n = 1'b0; we_n = 1'b0; addr = 4'd6; wdata = 32'h0BAD0BAD; wmask_n = 4'b0000;
            end else if (poke && n == 5) begin
                ce_n = 1'b0; we_n = 1'b1; addr = 4'd2;
            end else begin
                ce_n = 1'b1; we_n = 1'b1;
            end
            n++;
            @(negedge clk);
            chk({nm, "_busy_match"}, 32'(busy1), 32'(busy0));
        end
        ce_n = 1'b1; we_n = 1'b1;
        chk({nm, "_busy_cycles"}, n, 32'd12);
    endtask

    task automatic read_all();
        for (int i = 0; i < 12; i++) rd(i, model[i]);
    endtask

    initial begin
        cyc = 0; vectors = 0; miscompares = 0;
        rst_n = 1'b0; ce_n = 1'b1; we_n = 1'b1; wmask_n = 4'hF;
        addr = '0; wdata = '0; clr_req = 1'b0;
        for (int i = 0; i < 12; i++) model[i] = 32'hXXXXXXXX;

        // Reset values
        idle(3);
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_oor0", 32'(oor0), 32'd0);
        rst_n = 1'b1;
        count_busy("init", 1'b0);
        model_fill();
        read_all();

        // Masked writes, each read back on the following cycle
        wr(3, 32'h11223344, 4'b1010);
        rd(3, 32'hA522A544);
        wr(7, 32'hCAFEF00D, 4'b0000);
        rd(7, 32'hCAFEF00D);
        wr(8, 32'h01020304, 4'b0111);
        rd(8, 32'h01A5A5A5);
        wr(9, 32'h55667788, 4'b1111);
        rd(9, CV);
        rd(0, CV); rd(1, CV); rd(2, CV);
        idle(3);
        chk("oor_clean", 32'(oor0), 32'd0);

        // Out-of-range read and write
        rd(13, 32'd0);
        idle(2);
        chk("oor_set0", 32'(oor0), 32'd1);
        chk("oor_set1", 32'(oor1), 32'd1);
        wr(15, 32'hFFFFFFFF, 4'b0000);
        read_all();
        idle(2);
        chk("oor_hold", 32'(oor0), 32'd1);

        // Pre-clear read, then clear request with a same-cycle write
        rd(3, 32'hA522A544);
        clr_req = 1'b1;
        wr(5, 32'hDEADBEEF, 4'b0000);
        clr_req = 1'b0;
        chk("clr_busy_next", 32'(busy0), 32'd1);
        count_busy("clr", 1'b1);
        model_fill();
        rd(5, CV);
        rd(6, CV);
        read_all();
        idle(3);

        // Reset in the middle of a sweep restarts it from address 0
        wr(10, 32'h00000000, 4'b0000);
        wr(11, 32'h12345678, 4'b0000);
        rd(11, 32'h12345678);
        idle(3);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        idle(7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_oor0", 32'(oor0), 32'd0);
        chk("mid_rst_rdata0", rdata0, 32'd0);
        chk("mid_rst_rdata1", rdata1, 32'd0);
        count_busy("restart", 1'b0);
        model_fill();
        read_all();
        idle(4);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
